pulse_width_meter: RTL and testbench

Measures the high time of a single-bit input pulse in clock cycles. It is the measuring counterpart of the delay timer: the delay timer turns a configured period into a `done` event, and this block turns an observed pulse into a cycle count. It sits beside the delay timers in the base-modules library and is used for echo/response-time measurement and timing self-checks. Results are delivered over a valid/ready handshake and held until the consumer accepts them.

---
 rtl/base_pkg.sv | 25 ++
 rtl/pulse_width_meter_edge_detect.sv | 40 ++++
 rtl/pulse_width_meter.sv | 99 +++++++++
 tb/tb_pulse_width_meter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/base_pkg.sv
// base_pkg: shared types and helpers for the base-modules library.
//   pwm_state_t     - pulse_width_meter FSM states
//   calc_max_count  - MAX_PERIOD / CYCLE_TIME (integer division)
//   calc_cw         - counter width able to hold calc_max_count
package base_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEASURE   = 2'd2,
    HOLD      = 2'd3
  } pwm_state_t;

  function automatic int calc_max_count(input int max_period, input int cycle_time);
    return max_period / cycle_time;
  endfunction

  // At least one bit so a degenerate MAX_COUNT=0 still elaborates.
  function automatic int calc_cw(input int max_period, input int cycle_time);
    int m;
    m = calc_max_count(max_period, cycle_time);
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pulse_width_meter_edge_detect.sv
// edge_detect: conditions the measured input and flags rising edges.
//   clk, rst_n : clock, async active-low reset
//   sig_in     : raw input pulse
//   level      : conditioned level seen by the FSM
//   rise       : level & ~sig_d (one-cycle strobe)
// Option PULSE_WIDTH_METER_SYNC_EN: insert a 2-flop synchroniser (reset 0)
// ahead of the edge detector; otherwise sig_in is assumed synchronous.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic level,
  output logic rise
);

`ifdef PULSE_WIDTH_METER_SYNC_EN
  logic [1:0] sync_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[0], sig_in};
  end

  assign level = sync_pipe[1];
`else
  assign level = sig_in;
`endif

  // Previous conditioned level, tracked in every FSM state so a pulse
  // already high at arm time never looks like a fresh rise.
  logic sig_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_d <= 1'b0;
    else        sig_d <= level;
  end

  assign rise = level & ~sig_d;

endmodule

// File: rtl/pulse_width_meter.sv
// pulse_width_meter: measures the high time of sig_in in clock cycles and
// hands the result to a consumer over valid/ready.
//   MAX_PERIOD, CYCLE_TIME : MAX_COUNT = MAX_PERIOD / CYCLE_TIME
//   clk, rst_n             : clock, async active-low reset
//   arm                    : start one measurement (IDLE, or HOLD handshake)
//   sig_in                 : pulse being measured
//   busy                   : measurement in progress (WAIT_RISE/MEASURE)
//   result, overflow       : width in cycles, saturation flag
//   result_valid/ready     : output handshake, result held until accepted
// Option PULSE_WIDTH_METER_SYNC_EN (see edge_detect): adds 2 cycles of
// latency to busy falling / result_valid rising, widths unchanged.
module pulse_width_meter
  import base_pkg::*;
#(
  parameter  int MAX_PERIOD = 10000,
  parameter  int CYCLE_TIME = 10,
  localparam int MAX_COUNT  = calc_max_count(MAX_PERIOD, CYCLE_TIME),
  localparam int CW         = calc_cw(MAX_PERIOD, CYCLE_TIME)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          arm,
  input  logic          sig_in,
  output logic          busy,
  output logic [CW-1:0] result,
  output logic          result_valid,
  input  logic          result_ready,
  output logic          overflow
);

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_COUNT);

  pwm_state_t    state;
  logic [CW-1:0] cnt;
  logic          level;
  logic          rise;

  edge_detect u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .sig_in(sig_in),
    .level (level),
    .rise  (rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arm) begin
            cnt   <= '0;
            busy  <= 1'b1;
            state <= WAIT_RISE;
          end
        end
        WAIT_RISE: begin
          // The rising sample itself is the first counted cycle.
          if (rise) begin
            cnt   <= CW'(1);
            state <= MEASURE;
          end
        end
        MEASURE: begin
          if (level) begin
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;  // saturate, never wrap
          end else begin
            result       <= cnt;
            overflow     <= (cnt == CNT_MAX);
            result_valid <= 1'b1;
            busy         <= 1'b0;
            state        <= HOLD;
          end
        end
        HOLD: begin
          // result/overflow keep their value; only the handshake moves on.
          if (result_ready) begin
            result_valid <= 1'b0;
            if (arm) begin
              cnt   <= '0;
              busy  <= 1'b1;
              state <= WAIT_RISE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_width_meter.sv
module tb_pulse_width_meter;
  import base_pkg::*;

  localparam int MAXC = calc_max_count(10000, 10);
  localparam int CW   = calc_cw(10000, 10);
`ifdef PULSE_WIDTH_METER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic          clk;
  logic          rst_n;
  logic          arm;
  logic          sig_in;
  logic          busy;
  logic [CW-1:0] result;
  logic          result_valid;
  logic          result_ready;
  logic          overflow;

  pulse_width_meter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .arm         (arm),
    .sig_in      (sig_in),
    .busy        (busy),
    .result      (result),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Per-edge log since the last reset release: sig_in sampled at edge t,
  // and the outputs observed just after edge t.
  bit hist[$];
  bit vq[$];
  int rq[$];
  bit oq[$];
  bit bq[$];
  bit wv[$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit a, input bit s, input bit r);
    arm = a; sig_in = s; result_ready = r;
    hist.push_back(s);
    @(posedge clk); #1;
    vq.push_back(result_valid);
    rq.push_back(int'(result));
    oq.push_back(overflow);
    bq.push_back(busy);
  endtask

  task automatic clear_log();
    hist.delete(); vq.delete(); rq.delete(); oq.delete(); bq.delete();
  endtask

  task automatic add(input bit v, input int n);
    repeat (n) wv.push_back(v);
  endtask

  // Level the measurement logic sees at edge t (synchroniser delays by LAT).
  function automatic bit lvl(input int t);
    int i;
    i = t - LAT;
    if (i < 0 || i >= hist.size()) return 1'b0;
    return hist[i];
  endfunction

  // Reference: after arming at edge a, the first fresh rise at t > a starts
  // a run of N high samples; the result appears at the first low sample.
  task automatic model(input int a, output int ve, output int res, output bit ov);
    bit found;
    int n, u;
    ve = -1; res = 0; ov = 1'b0; found = 1'b0;
    for (int t = a + 1; t < hist.size() && !found; t++) begin
      if (lvl(t) && !lvl(t - 1)) begin
        found = 1'b1;
        n = 0; u = t;
        while (u < hist.size() && lvl(u)) begin n++; u++; end
        if (u < hist.size()) begin
          ve  = u;
          res = (n > MAXC) ? MAXC : n;
          ov  = (n >= MAXC);
        end
      end
    end
  endtask

  // Arm on wv[0], play wv with result_ready=1, then check against the model.
  task automatic run_meas(input string tag, output int r_obs, output int o_obs);
    int a, ve, res, ve_obs;
    bit ov;
    a = hist.size();
    ve_obs = -1; r_obs = -1; o_obs = -1;
    foreach (wv[k]) tick(k == 0, wv[k], 1'b1);
    model(a, ve, res, ov);
    for (int i = a; i < vq.size(); i++)
      if (vq[i] && ve_obs < 0) ve_obs = i;
    chk({tag, "_busy_arm"}, bq[a], 1);
    chk({tag, "_valid_edge"}, ve_obs - a, ve - a);
    if (ve_obs >= 0) begin
      r_obs = rq[ve_obs];
      o_obs = oq[ve_obs];
      chk({tag, "_result"}, rq[ve_obs], res);
      chk({tag, "_overflow"}, oq[ve_obs], ov);
      chk({tag, "_busy_done"}, bq[ve_obs], 0);
      if (ve_obs + 1 < vq.size()) chk({tag, "_valid_drop"}, vq[ve_obs + 1], 0);
    end
    wv.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int r, o, w, k;
    rst_n = 1'b0; arm = 1'b0; sig_in = 1'b0; result_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_result", int'(result), 0);
    chk("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    tick(0, 0, 1); tick(0, 1, 1); tick(0, 0, 1);
    chk("idle_ignores_sig", bq[$] | vq[$], 0);

    // 37-cycle pulse
    add(0, 1); add(1, 37); add(0, LAT + 4);
    run_meas("t1", r, o);
    chk("t1_const", r, 37);

    // already high when armed -> measures the later 12-cycle pulse
    repeat (3) tick(0, 1, 1);
    add(1, 6); add(0, 3); add(1, 12); add(0, LAT + 4);
    run_meas("t2", r, o);
    chk("t2_const", r, 12);

    // saturation and boundaries around MAX_COUNT
    add(0, 1); add(1, 1500); add(0, LAT + 4);
    run_meas("t3", r, o);
    chk("t3_const", r, MAXC);
    chk("t3_ovf", o, 1);
    add(0, 1); add(1, MAXC); add(0, LAT + 4);
    run_meas("t3_max", r, o);
    chk("t3_max_ovf", o, 1);
    add(0, 1); add(1, MAXC - 1); add(0, LAT + 4);
    run_meas("t3_below", r, o);
    chk("t3_below_ovf", o, 0);
    add(0, 1); add(1, 1); add(0, LAT + 4);
    run_meas("t3_one", r, o);
    chk("t3_one_const", r, 1);

    // hold with ready low; second pulse and arm ignored
    tick(1, 0, 0);
    repeat (9) tick(0, 1, 0);
    for (int i = 0; i < LAT + 3; i++) begin
      tick(0, 0, 0);
      if (vq[$]) break;
    end
    chk("t4_valid", vq[$], 1);
    chk("t4_result", rq[$], 9);
    for (int i = 0; i < 20; i++) begin
      tick(i % 7 == 3, i >= 4 && i < 10, 0);
      chk("t4_hold_valid", vq[$], 1);
      chk("t4_hold_result", rq[$], 9);
      chk("t4_hold_busy", bq[$], 0);
    end
    tick(0, 0, 1);
    chk("t4_hs_valid", vq[$], 0);
    chk("t4_hs_busy", bq[$], 0);
    for (int i = 0; i < 6; i++) begin
      tick(0, i % 2 == 1, 1);
      chk("t4_idle_busy", bq[$], 0);
      chk("t4_idle_valid", vq[$], 0);
    end

    // back-to-back via arm on handshake
    tick(1, 0, 0);
    repeat (6) tick(0, 1, 0);
    for (int i = 0; i < LAT + 3; i++) begin
      tick(0, 0, 0);
      if (vq[$]) break;
    end
    chk("t6_first", rq[$], 6);
    tick(1, 0, 1);
    chk("t6_hs_valid", vq[$], 0);
    chk("t6_hs_busy", bq[$], 1);
    repeat (4) tick(0, 1, 1);
    for (int i = 0; i < LAT + 3; i++) begin
      tick(0, 0, 1);
      if (vq[$]) break;
    end
    chk("t6_second_valid", vq[$], 1);
    chk("t6_second", rq[$], 4);
    tick(0, 0, 1);

    // reset mid-measurement
    tick(1, 0, 1);
    repeat (9) tick(0, 1, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_valid", result_valid, 0);
    chk("t5_rst_result", int'(result), 0);
    chk("t5_rst_overflow", overflow, 0);
    sig_in = 1'b0; arm = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    clear_log();
    repeat (3) tick(0, 0, 1);
    chk("t5_no_result", vq[$] | bq[$], 0);
    add(0, 1); add(1, 4); add(0, LAT + 4);
    run_meas("t5", r, o);
    chk("t5_const", r, 4);

    // randomized measurements
    for (int it = 0; it < 20; it++) begin
      repeat ($urandom_range(1, 3)) tick(0, 1'($urandom_range(0, 1)), 1);
      k = $urandom_range(0, 4);
      for (int j = 0; j < k; j++) add(1'($urandom_range(0, 1)), 1);
      add(0, 1);
      w = ($urandom_range(0, 7) == 0) ? $urandom_range(900, 1100) : $urandom_range(1, 40);
      add(1, w);
      add(0, 1);
      for (int j = 0; j < LAT + 3; j++) add(1'($urandom_range(0, 1)), 1);
      run_meas("rnd", r, o);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
